// File: rtl/ysyx_22041405_wbu.sv
// Write-back unit: retires ALU results and aligned load data into the register file.
// Optional forwarding outputs are enabled by defining YSYX_22041405_WBU_FWD_EN.
module ysyx_22041405_wbu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_we,
    input  logic             in_is_load,
    input  logic [2:0]       in_load_fmt,
    input  logic [WIDTH-1:0] in_alu_result,
    input  logic             mem_rvalid,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             commit_valid,
    output logic [WIDTH-1:0] commit_pc,
    output logic [31:0]      retired_cnt
`ifdef YSYX_22041405_WBU_FWD_EN
    ,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [WIDTH-1:0] fwd_data
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pc_q, pc_d;
    logic [4:0]         rd_q, rd_d;
    logic               rd_we_q, rd_we_d;
    logic [2:0]         fmt_q, fmt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               rf_we_q, rf_we_d;
    logic [4:0]         rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
    logic               commit_valid_q, commit_valid_d;
    logic [WIDTH-1:0]   commit_pc_q, commit_pc_d;
    logic [31:0]        retired_cnt_q, retired_cnt_d;
    logic               accept_c;

    // Extract and extend the addressed byte/halfword from the aligned load word.
    function automatic logic [WIDTH-1:0] load_ext(input logic [WIDTH-1:0] word,
                                                  input logic [2:0]       fmt,
                                                  input logic [1:0]       off);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (fmt)
            3'd0:    load_ext = {{(WIDTH-8){b[7]}}, b};
            3'd1:    load_ext = {{(WIDTH-16){h[15]}}, h};
            3'd4:    load_ext = WIDTH'(b);
            3'd5:    load_ext = WIDTH'(h);
            default: load_ext = word;
        endcase
    endfunction

    assign in_ready = rst && (state_q != WAIT_MEM);
    assign accept_c = in_valid && in_ready;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        rd_d           = rd_q;
        rd_we_d        = rd_we_q;
        fmt_d          = fmt_q;
        res_d          = res_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_valid_d = 1'b0;
        commit_pc_d    = commit_pc_q;
        retired_cnt_d  = retired_cnt_q;

        case (state_q)
            WAIT_MEM: begin
                if (mem_rvalid) begin
                    state_d        = COMMIT;
                    rf_we_d        = rd_we_q && (rd_q != 5'd0);
                    rf_waddr_d     = rd_q;
                    rf_wdata_d     = load_ext(mem_rdata, fmt_q, res_q[1:0]);
                    commit_valid_d = 1'b1;
                    commit_pc_d    = pc_q;
                    retired_cnt_d  = retired_cnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // New acceptance in IDLE/COMMIT; COMMIT outputs stay on the old registers until the edge.
        if (accept_c) begin
            pc_d    = in_pc;
            rd_d    = in_rd;
            rd_we_d = in_rd_we;
            fmt_d   = in_load_fmt;
            res_d   = in_alu_result;
            if (in_is_load) begin
                state_d = WAIT_MEM;
            end else begin
                state_d        = COMMIT;
                rf_we_d        = in_rd_we && (in_rd != 5'd0);
                rf_waddr_d     = in_rd;
                rf_wdata_d     = in_alu_result;
                commit_valid_d = 1'b1;
                commit_pc_d    = in_pc;
                retired_cnt_d  = retired_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            pc_q           <= '0;
            rd_q           <= '0;
            rd_we_q        <= 1'b0;
            fmt_q          <= '0;
            res_q          <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            retired_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            rd_we_q        <= rd_we_d;
            fmt_q          <= fmt_d;
            res_q          <= res_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            retired_cnt_q  <= retired_cnt_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign retired_cnt  = retired_cnt_q;

`ifdef YSYX_22041405_WBU_FWD_EN
    assign fwd_valid = rf_we_q;
    assign fwd_rd    = rf_waddr_q;
    assign fwd_data  = rf_wdata_q;
`endif

endmodule

// File: tb/tb_ysyx_22041405_wbu.sv
// Self-checking bench for ysyx_22041405_wbu: directed scenarios plus randomized loads
// and back-to-back ALU streams checked against an arithmetic reference model.
module tb_ysyx_22041405_wbu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rd;
    logic        in_rd_we;
    logic        in_is_load;
    logic [2:0]  in_load_fmt;
    logic [31:0] in_alu_result;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [31:0] retired_cnt;

    int          total;
    int          bad;
    logic [31:0] exp_cnt;

    ysyx_22041405_wbu #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_rd         (in_rd),
        .in_rd_we      (in_rd_we),
        .in_is_load    (in_is_load),
        .in_load_fmt   (in_load_fmt),
        .in_alu_result (in_alu_result),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .retired_cnt   (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference load semantics: pick byte/halfword arithmetically, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] fmt, input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned off, b, h;
        off = addr % 4;
        b   = (word / (32'd1 << (8 * off))) % 256;
        h   = (word / (32'd1 << (16 * (off / 2)))) % 65536;
        case (fmt)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid      = 1'b0;
        in_pc         = $urandom;
        in_rd         = 5'($urandom);
        in_rd_we      = 1'b1;
        in_is_load    = 1'b0;
        in_load_fmt   = 3'($urandom);
        in_alu_result = $urandom;
        mem_rvalid    = 1'b0;
        mem_rdata     = $urandom;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        in_valid = 1'b1;
        tick();
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if ({rf_we, commit_valid} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%b exp=00", {rf_we, commit_valid}); end
        total++; if (retired_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", retired_cnt); end
        total++; if ({rf_waddr, rf_wdata, commit_pc} !== 69'd0) begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", rf_waddr, rf_wdata, commit_pc); end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        exp_cnt = 32'd0;
    endtask

    task automatic test_alu_op;
        in_valid = 1'b1; in_is_load = 1'b0; in_pc = 32'h8000_0000; in_rd = 5'd5; in_rd_we = 1'b1;
        in_alu_result = 32'h1234;
        tick();
        idle_inputs();
        exp_cnt++;
        total++; if ({rf_we, rf_waddr, commit_valid} !== {1'b1, 5'd5, 1'b1}) begin bad++; $display("FAIL alu_ctrl got=%b/%0d/%b exp=1/5/1", rf_we, rf_waddr, commit_valid); end
        total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL alu_data got=%h exp=00001234", rf_wdata); end
        total++; if (commit_pc !== 32'h8000_0000) begin bad++; $display("FAIL alu_pc got=%h exp=80000000", commit_pc); end
        total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL alu_cnt got=%h exp=%h", retired_cnt, exp_cnt); end
        tick();
        total++; if ({rf_we, commit_valid, in_ready} !== 3'b001) begin bad++; $display("FAIL alu_after got=%b exp=001", {rf_we, commit_valid, in_ready}); end
    endtask

    task automatic test_rd0;
        in_valid = 1'b1; in_is_load = 1'b0; in_pc = 32'h8000_0010; in_rd = 5'd0; in_rd_we = 1'b1;
        in_alu_result = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        exp_cnt++;
        total++; if ({rf_we, commit_valid} !== 2'b01) begin bad++; $display("FAIL rd0_strobes got=%b exp=01", {rf_we, commit_valid}); end
        total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL rd0_cnt got=%h exp=%h", retired_cnt, exp_cnt); end
        tick();
    endtask

    // One load: garbage rvalid on the acceptance cycle, then data `gap` cycles after acceptance.
    task automatic test_load(input logic [2:0] fmt, input logic [31:0] addr, input logic [31:0] word,
                             input int gap, input logic [4:0] rd, input logic we,
                             input logic [31:0] want, input string name);
        logic [31:0] pc;
        pc = $urandom;
        in_valid = 1'b1; in_is_load = 1'b1; in_load_fmt = fmt; in_alu_result = addr;
        in_pc = pc; in_rd = rd; in_rd_we = we;
        mem_rvalid = 1'b1; mem_rdata = ~word;
        tick();
        idle_inputs();
        for (int i = 1; i < gap; i++) begin
            total++; if ({in_ready, commit_valid, rf_we} !== 3'b000) begin bad++; $display("FAIL %s_wait got=%b exp=000", name, {in_ready, commit_valid, rf_we}); end
            tick();
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s_ready got=%b exp=0", name, in_ready); end
        mem_rvalid = 1'b1; mem_rdata = word;
        tick();
        mem_rvalid = 1'b0;
        exp_cnt++;
        total++; if (rf_wdata !== want) begin bad++; $display("FAIL %s_data got=%h exp=%h", name, rf_wdata, want); end
        total++; if ({rf_we, rf_waddr, commit_valid, commit_pc} !== {we && (rd != 5'd0), rd, 1'b1, pc}) begin
            bad++; $display("FAIL %s_ctrl got=%b/%0d/%b/%h exp=%b/%0d/1/%h", name, rf_we, rf_waddr, commit_valid, commit_pc, we && (rd != 5'd0), rd, pc);
        end
        total++; if ({retired_cnt, in_ready} !== {exp_cnt, 1'b1}) begin bad++; $display("FAIL %s_cnt got=%h/%b exp=%h/1", name, retired_cnt, in_ready, exp_cnt); end
    endtask

    task automatic test_directed_loads;
        test_load(3'd0, 32'h0000_1003, 32'h80FF_FF00, 3, 5'd10, 1'b1, 32'hFFFF_FF80, "lb");
        test_load(3'd5, 32'h0000_2002, 32'hBEEF_0000, 2, 5'd11, 1'b1, 32'h0000_BEEF, "lhu");
        test_load(3'd1, 32'h0000_2003, 32'hBEEF_0000, 1, 5'd12, 1'b1, 32'hFFFF_BEEF, "lh");
        test_load(3'd7, 32'h0000_3001, 32'hCAFE_F00D, 2, 5'd13, 1'b1, 32'hCAFE_F00D, "fmt7");
        tick();
    endtask

    task automatic test_random_loads;
        logic [2:0]  fmt;
        logic [31:0] addr, word;
        for (int n = 0; n < 30; n++) begin
            fmt  = 3'($urandom_range(0, 7));
            addr = $urandom;
            word = $urandom;
            test_load(fmt, addr, word, int'($urandom_range(1, 4)), 5'($urandom), 1'($urandom),
                      model_load(fmt, addr, word), "rnd_load");
            if ($urandom_range(0, 1) == 1) tick();
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] pcs[12];
        logic [31:0] res[12];
        logic [4:0]  rds[12];
        logic        wes[12];
        logic [31:0] word, addr;
        force dut.retired_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.retired_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        for (int i = 0; i < 12; i++) begin
            pcs[i] = $urandom; res[i] = $urandom; rds[i] = 5'($urandom); wes[i] = 1'($urandom);
        end
        in_valid = 1'b1; in_is_load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_pc = pcs[i]; in_alu_result = res[i]; in_rd = rds[i]; in_rd_we = wes[i];
            tick();
            exp_cnt++;
            total++; if ({rf_we, rf_waddr, rf_wdata} !== {wes[i] && (rds[i] != 5'd0), rds[i], res[i]}) begin
                bad++; $display("FAIL b2b_write[%0d] got=%b/%0d/%h exp=%b/%0d/%h", i, rf_we, rf_waddr, rf_wdata, wes[i] && (rds[i] != 5'd0), rds[i], res[i]);
            end
            total++; if ({commit_valid, commit_pc, in_ready} !== {1'b1, pcs[i], 1'b1}) begin
                bad++; $display("FAIL b2b_commit[%0d] got=%b/%h/%b exp=1/%h/1", i, commit_valid, commit_pc, in_ready, pcs[i]);
            end
            total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_cnt[%0d] got=%h exp=%h", i, retired_cnt, exp_cnt); end
        end
        // Load accepted during COMMIT with a stray rvalid on the same cycle.
        word = $urandom; addr = $urandom;
        in_is_load = 1'b1; in_load_fmt = 3'd4; in_alu_result = addr; in_rd = 5'd3; in_rd_we = 1'b1;
        in_pc = 32'h8000_0100; mem_rvalid = 1'b1; mem_rdata = ~word;
        tick();
        idle_inputs();
        total++; if ({commit_valid, rf_we, in_ready} !== 3'b000) begin bad++; $display("FAIL b2b_load_wait got=%b exp=000", {commit_valid, rf_we, in_ready}); end
        mem_rvalid = 1'b1; mem_rdata = word;
        tick();
        mem_rvalid = 1'b0;
        exp_cnt++;
        total++; if ({rf_we, rf_wdata, commit_pc} !== {1'b1, model_load(3'd4, addr, word), 32'h8000_0100}) begin
            bad++; $display("FAIL b2b_load got=%b/%h/%h exp=1/%h/80000100", rf_we, rf_wdata, commit_pc, model_load(3'd4, addr, word));
        end
        total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL b2b_load_cnt got=%h exp=%h", retired_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_reset_in_wait;
        in_valid = 1'b1; in_is_load = 1'b1; in_load_fmt = 3'd2; in_alu_result = 32'h100;
        in_rd = 5'd7; in_rd_we = 1'b1;
        tick();
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstwait_ready_low got=%b exp=0", in_ready); end
        tick();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        exp_cnt = 32'd0;
        total++; if ({rf_we, commit_valid} !== 2'b00) begin bad++; $display("FAIL rstwait_strobes got=%b exp=00", {rf_we, commit_valid}); end
        total++; if (retired_cnt !== exp_cnt) begin bad++; $display("FAIL rstwait_cnt got=%h exp=%h", retired_cnt, exp_cnt); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstwait_ready got=%b exp=1", in_ready); end
        tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL rstwait_late got=%b exp=0", commit_valid); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_cnt = 32'd0;
        test_reset();
        test_alu_op();
        test_rd0();
        test_directed_loads();
        test_random_loads();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
